fifo_write: RTL and testbench

//  Writer-side counterpart of the FIFO byte reader. On an fs/fd start-done handshake, moves

---
 rtl/fifo_write_pkg.sv | 15 +
 rtl/fifo_write.sv | 110 +++++++++++
 tb/tb_fifo_write.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_pkg.sv
// Shared constants for the FIFO writer/reader fs/fd handshake blocks.
package fifo_write_pkg;

  // Handshake state codes, shared with the FIFO byte reader.
  typedef enum logic [7:0] {
    IDLE = 8'h00,
    WORK = 8'h01,
    DONE = 8'h02
  } fifo_state_e;

  localparam int unsigned LEN_W_DEFAULT = 12;
  localparam int unsigned TMO_W_DEFAULT = 16;
  localparam int unsigned TMO_DEFAULT   = 4096;

endpackage

// File: rtl/fifo_write.sv
// FIFO writer: on an fs/fd handshake, moves data_len bytes from a valid/ready
// byte source straight into a FIFO write port, with stall timeout and abort
// reporting on a sticky err flag.
module fifo_write
  import fifo_write_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = LEN_W_DEFAULT,
  parameter int unsigned TMO_W  = TMO_W_DEFAULT,
  parameter int unsigned TMO    = TMO_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fs,
  output logic              fd,
  output logic              err,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [DATA_W-1:0] src_rxd,
  input  logic              src_rxen,
  output logic              src_rdy,
  output logic [DATA_W-1:0] fifo_txd,
  output logic              fifo_txen,
  input  logic              fifo_full
);

  localparam logic [TMO_W-1:0] STALL_LAST = TMO_W'(TMO - 1);

  fifo_state_e       state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TMO_W-1:0]  stall_q, stall_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;
  logic              xfer;

  // State, counters and flags; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      stall_q <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      stall_q <= stall_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counters and zero-latency source-to-FIFO pass-through.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    stall_d   = stall_q;
    err_d     = err_q;
    src_rdy   = 1'b0;
    xfer      = 1'b0;
    fifo_txen = 1'b0;
    fifo_txd  = src_rxd;

    unique case (state_q)
      IDLE: begin
        if (fs) begin
          len_d   = data_len;
          cnt_d   = '0;
          stall_d = '0;
          err_d   = 1'b0;
          state_d = (data_len == '0) ? DONE : WORK;
        end
      end
      WORK: begin
        src_rdy   = ~fifo_full;
        xfer      = src_rxen & src_rdy;
        fifo_txen = xfer;
        if (!fs) begin
          // Master withdrew the start: abort without fd.
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (xfer) begin
          // A transfer on the timeout cycle wins over the timeout.
          cnt_d   = cnt_q + LEN_W'(1);
          stall_d = '0;
          if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
        end else if (stall_q == STALL_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          stall_d = stall_q + TMO_W'(1);
        end
      end
      DONE: begin
        if (!fs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // fd is registered so it follows the state register by design.
    fd_d = (state_d == DONE);
  end

  assign fd  = fd_q;
  assign err = err_q;

endmodule

// File: tb/tb_fifo_write.sv
// Directed self-checking bench for fifo_write with a byte scoreboard.
module tb_fifo_write;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned TMO    = 16;

  logic              clk;
  logic              rst_n;
  logic              fs;
  logic              fd;
  logic              err;
  logic [LEN_W-1:0]  data_len;
  logic [DATA_W-1:0] src_rxd;
  logic              src_rxen;
  logic              src_rdy;
  logic [DATA_W-1:0] fifo_txd;
  logic              fifo_txen;
  logic              fifo_full;

  int checks   = 0;
  int failures = 0;
  int txen_cnt = 0;
  bit rdy_seen = 1'b0;
  logic [DATA_W-1:0] sb[$];

  fifo_write #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .TMO_W (16),
    .TMO   (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fs       (fs),
    .fd       (fd),
    .err      (err),
    .data_len (data_len),
    .src_rxd  (src_rxd),
    .src_rxen (src_rxen),
    .src_rdy  (src_rdy),
    .fifo_txd (fifo_txd),
    .fifo_txen(fifo_txen),
    .fifo_full(fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest outstanding byte.
  always @(negedge clk) begin
    if (src_rdy) rdy_seen = 1'b1;
    if (fifo_txen === 1'b1) begin
      txen_cnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 32'(fifo_txd), 32'hFFFF_FFFF);
      end else begin
        chk("sb_data", 32'(fifo_txd), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [LEN_W-1:0] len);
    fs       = 1'b1;
    data_len = len;
    tick();
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic send(input logic [DATA_W-1:0] b);
    bit ok;
    ok       = 1'b0;
    src_rxd  = b;
    src_rxen = 1'b1;
    sb.push_back(b);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    tick();
    src_rxen = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    fs        = 1'b0;
    data_len  = '0;
    src_rxd   = '0;
    src_rxen  = 1'b0;
    fifo_full = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fd", fd, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdy", src_rdy, 1'b0);
    chk("rst_txen", fifo_txen, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: four back-to-back bytes
    txen_cnt = 0;
    start(12'd4);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t1_fd", fd, 1'b1);
    chk("t1_txen_cnt", 32'(txen_cnt), 32'd4);
    chk("t1_err", err, 1'b0);
    fs = 1'b0;
    chk("t1_fd_hold", fd, 1'b1);
    tick();
    chk("t1_fd_drop", fd, 1'b0);

    // 2: FIFO full for three cycles after byte 2
    txen_cnt = 0;
    start(12'd6);
    send(8'hA1); send(8'hA2);
    fifo_full = 1'b1;
    src_rxd   = 8'hA3;
    src_rxen  = 1'b1;
    sb.push_back(8'hA3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_rdy_full", src_rdy, 1'b0);
      chk("t2_txen_full", fifo_txen, 1'b0);
      tick();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("t2_rdy_resume", src_rdy, 1'b1);
    tick();
    src_rxen = 1'b0;
    send(8'hA4); send(8'hA5); send(8'hA6);
    chk("t2_fd", fd, 1'b1);
    chk("t2_err", err, 1'b0);
    chk("t2_txen_cnt", 32'(txen_cnt), 32'd6);
    fs = 1'b0;
    tick();

    // 3: zero length goes straight to DONE
    txen_cnt = 0;
    rdy_seen = 1'b0;
    start(12'd0);
    chk("t3_fd", fd, 1'b1);
    tick();
    chk("t3_fd_stay", fd, 1'b1);
    chk("t3_txen_cnt", 32'(txen_cnt), 32'd0);
    chk("t3_rdy_seen", 32'(rdy_seen), 32'd0);
    fs = 1'b0;
    tick();

    // 4: stall timeout, then a clean restart clears err
    start(12'd5);
    send(8'hB1); send(8'hB2);
    repeat (TMO - 1) tick();
    chk("t4_fd_pre", fd, 1'b0);
    chk("t4_err_pre", err, 1'b0);
    tick();
    chk("t4_err", err, 1'b1);
    chk("t4_fd", fd, 1'b1);
    fs = 1'b0;
    tick();
    tick();
    chk("t4_err_sticky", err, 1'b1);
    start(12'd1);
    chk("t4_err_clr", err, 1'b0);
    send(8'hB3);
    chk("t4_fd2", fd, 1'b1);
    chk("t4_err2", err, 1'b0);
    fs = 1'b0;
    tick();

    // 5: abort, then last byte on the timeout cycle
    start(12'd5);
    send(8'hC1); send(8'hC2);
    fs = 1'b0;
    tick();
    chk("t5_err_abort", err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_fd_abort", fd, 1'b0);
      chk("t5_rdy_abort", src_rdy, 1'b0);
      tick();
    end
    start(12'd1);
    repeat (TMO - 1) tick();
    chk("t5_fd_pre", fd, 1'b0);
    send(8'hC3);
    chk("t5_fd_race", fd, 1'b1);
    chk("t5_err_race", err, 1'b0);
    fs = 1'b0;
    tick();

    // 6: data_len change ignored; async reset mid-WORK
    start(12'd3);
    send(8'hD1);
    data_len = 12'd1;
    send(8'hD2);
    chk("t6_fd_early", fd, 1'b0);
    send(8'hD3);
    chk("t6_fd", fd, 1'b1);
    fs = 1'b0;
    tick();
    start(12'd5);
    send(8'hE1);
    src_rxd  = 8'hE2;
    src_rxen = 1'b1;
    #1;
    chk("t6_rdy_pre", src_rdy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_fd", fd, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    chk("t6_rst_txen", fifo_txen, 1'b0);
    chk("t6_rst_rdy", src_rdy, 1'b0);
    src_rxen = 1'b0;
    fs       = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle_rdy", src_rdy, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
